// File: rtl/rv_decode_ctrl.sv
// ---------------------------------------------------------------------------
// rv_decode_ctrl
//   Multi-cycle RV32I sequencer/decoder driving the control side of the core
//   ALU. Each instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK.
//   Supported: R-type ALU ops, I-type ALU ops, LUI. Any other opcode retires
//   as a no-op with a one-cycle illegal pulse.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata    instruction fetch handshake (addr == pc)
//   rs1_addr, rs2_addr         register file read addresses from instr reg
//   rf_rdata1, rf_rdata2       combinational register file read data
//   alu_a/b/funct3/funct7/
//   alu_instr_type             ALU control, active only during EXECUTE
//   alu_c                      ALU result
//   rf_we/waddr/wdata          register file write port (WRITEBACK pulse)
//   pc                         current program counter
//   illegal                    one-cycle pulse on an unsupported opcode
// ---------------------------------------------------------------------------
module rv_decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic [3:0]  alu_instr_type,
    input  logic [31:0] alu_c,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    // ALU instr_type encoding
    localparam logic [3:0] T_R = 4'd0;
    localparam logic [3:0] T_I = 4'd1;
    localparam logic [3:0] T_U = 4'd4;
    localparam logic [3:0] T_N = 4'd7;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [3:0]  r_type;
    logic [31:0] r_imm;
    logic        r_b_imm;     // operand b comes from r_imm instead of rs2
    logic        r_legal;
    logic [31:0] r_wb_data;

    logic [3:0]  w_type;
    logic [31:0] w_imm;
    logic        w_b_imm;
    logic        w_legal;
    logic        w_rd_nz;

    // ------------------------------------------------------------------
    // Decode of the instruction register (registered at end of DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        w_type  = T_N;
        w_imm   = 32'd0;
        w_b_imm = 1'b1;       // illegal ops present b=0 via a zero imm
        w_legal = 1'b0;
        case (r_instr[6:0])
            OP_R: begin
                w_type  = T_R;
                w_b_imm = 1'b0;
                w_legal = 1'b1;
            end
            OP_I: begin
                w_type  = T_I;
                w_imm   = {{20{r_instr[31]}}, r_instr[31:20]};
                w_legal = 1'b1;
            end
            OP_LUI: begin
                w_type  = T_U;
                w_imm   = {r_instr[31:12], 12'd0};
                w_legal = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_type    <= T_N;
            r_imm     <= 32'd0;
            r_b_imm   <= 1'b0;
            r_legal   <= 1'b0;
            r_wb_data <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) r_instr <= imem_rdata;
                end
                S_DECODE: begin
                    r_type  <= w_type;
                    r_imm   <= w_imm;
                    r_b_imm <= w_b_imm;
                    r_legal <= w_legal;
                end
                S_EXECUTE: begin
                    // LUI bypasses the ALU entirely
                    r_wb_data <= (r_type == T_U) ? r_imm : alu_c;
                end
                S_WRITEBACK: begin
                    r_pc <= r_pc + PC_STEP;
                end
                default: ;
            endcase
        end
    end

    assign w_rd_nz = |r_instr[11:7];

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        imem_req       = 1'b0;
        alu_a          = 32'd0;
        alu_b          = 32'd0;
        alu_funct3     = 3'd0;
        alu_funct7     = 7'd0;
        alu_instr_type = T_N;
        rf_we          = 1'b0;
        illegal        = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Gated by rst_n so the request is low while reset is held
                // even though the state register already sits in FETCH.
                imem_req = rst_n;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_a          = rf_rdata1;
                alu_b          = r_b_imm ? r_imm : rf_rdata2;
                alu_funct3     = r_instr[14:12];
                alu_funct7     = r_instr[31:25];
                alu_instr_type = r_type;
                w_next         = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we   = r_legal & w_rd_nz;
                illegal = ~r_legal;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign rs1_addr  = r_instr[19:15];
    assign rs2_addr  = r_instr[24:20];
    assign rf_waddr  = r_instr[11:7];
    assign rf_wdata  = r_wb_data;

endmodule

// File: doc/rv_decode_ctrl.md
Name: rv_decode_ctrl

Overview:
- Multi-cycle instruction sequencer and decoder that drives the existing ALU's control side.
- Fetches a 32-bit RV32I word over a req/ack instruction-memory port and decodes opcode/funct3/funct7 into the ALU's instr_type/funct3/funct7 encoding.
- Generates the immediate, selects ALU operand b, and writes the ALU result back to the register file.
- Sits between instruction memory, register file and ALU in the TP2 core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 32'd4, PC increment per retired instruction.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held high until acknowledged
- imem_addr  out  32  fetch address (equals pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction word
- rs1_addr  out  5  register file read address 1 (instr[19:15])
- rs2_addr  out  5  register file read address 2 (instr[24:20])
- rf_rdata1  in  32  combinational read data for rs1
- rf_rdata2  in  32  combinational read data for rs2
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_funct3  out  3  to ALU funct3_
- alu_funct7  out  7  to ALU funct7_
- alu_instr_type  out  4  to ALU instr_type
- alu_c  in  32  ALU result
- rf_we  out  1  register write enable, one-cycle pulse
- rf_waddr  out  5  destination register (instr[11:7])
- rf_wdata  out  32  write-back data
- pc  out  32  current program counter
- illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (async, rst_n low): state=FETCH, pc=RESET_PC, instr register=0, wb_data=0, rf_we=0, illegal=0, imem_req=0.
- Reset deassertion: imem_req rises in the first FETCH cycle after reset is released.
- FSM states: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a rising edge with imem_ack=1, latch imem_rdata into the instr register and go to DECODE.
  - Otherwise stay in FETCH with imem_req held high.
- DECODE (1 cycle): register type, imm and the wb_sel/legal flags from instr.
  - opcode 0110011 -> type 0 (R), b=rf_rdata2.
  - opcode 0010011 -> type 1 (I), b=sign-extend(instr[31:20]).
  - opcode 0110111 -> type 4 (U), imm={instr[31:12],12'b0}; write-back bypasses the ALU.
  - Any other opcode -> type 7 (N), legal=0.
- EXECUTE (1 cycle):
  - alu_a=rf_rdata1; alu_b per the DECODE selection.
  - alu_funct3=instr[14:12], alu_funct7=instr[31:25], alu_instr_type=registered type.
  - End of cycle: wb_data <= (type U ? imm : alu_c).
- WRITEBACK (1 cycle):
  - rf_we=1 only if legal and rd!=0; rf_waddr=instr[11:7]; rf_wdata=wb_data.
  - illegal=1 if !legal.
  - pc <= pc+PC_STEP (wraps modulo 2^32). Next state FETCH.
- ALU outputs outside EXECUTE: alu_a, alu_b, alu_funct3, alu_funct7 = 0; alu_instr_type = 7.
- rs1_addr/rs2_addr track the instr register continuously.
- Latency: 4 cycles per instruction when imem_ack is high in the first FETCH cycle; add 1 cycle per wait cycle.
- Reset mid-instruction aborts with no write; a pending fetch is dropped.
- imem_ack outside FETCH is ignored.

Test Plan:
- Reset with rf_rdata1=5, rf_rdata2=3, then ack 0x002081B3 (ADD x3,x1,x2) -> EXECUTE shows type=0/f3=0/f7=0, a=5, b=3; WRITEBACK shows rf_we=1, waddr=3, wdata=8; pc 0->4; 4 cycles total.
- 0x402081B3 (SUB) with a=5, b=3 -> f7=0x20, wdata=2. 0x4020D233 (SRA x4) with a=0x80000000, b=4 -> f3=5, wdata=0xF8000000.
- 0xFFF00293 (ADDI x5,x0,-1) with rf_rdata1=0 -> type=1, alu_b=0xFFFFFFFF, waddr=5, wdata=0xFFFFFFFF.
- 0x123453B7 (LUI x7) -> wdata=0x12345000 regardless of alu_c; 0x00208033 (ADD x0) -> rf_we stays 0, pc still +4.
- Opcode 0x0000006F (JAL) -> illegal pulses 1 cycle in WRITEBACK, rf_we=0, pc+=4. imem_ack delayed 3 cycles -> imem_req held, imem_addr stable, total 7 cycles.
- rst_n low during EXECUTE -> outputs reset immediately, no rf_we, pc=RESET_PC. Then start with pc=0xFFFFFFFC -> pc wraps to 0.
